// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal on the shared memory port arbiter:
// the instruction-fetch port, the data (LSU) port, the single memory port
// and the outstanding-transaction count.
// The slave view belongs to the arbiter. The master view belongs to
// whatever drives the core and memory sides.
interface mem_port_arbiter_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;

    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    logic [3:0]  outstanding_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output outstanding_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  outstanding_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one OBI-style memory port between the instruction-fetch port and
// the data (LSU) port.
// - Data normally wins arbitration. After STARVE_LIMIT consecutive data grants
//   with a fetch waiting, the fetch wins instead.
// - An ungranted request keeps its selection locked until the memory grants it.
// - A small ID FIFO records who owns each outstanding transaction, so that the
//   in-order responses can be steered back to the requester that issued them.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic SEL_INSTR = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    localparam logic [3:0]       MAX_CNT  = 4'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    logic [MAX_OUTSTANDING-1:0] id_fifo_q;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [3:0]                 count_q;
    logic                       lock_q;
    logic                       sel_q;
    logic [STV_W-1:0]           starve_cnt_q;

    logic full;
    logic fifo_empty;
    logic sel;
    logic mem_req;
    logic push;
    logic pop;
    logic head_is_data;
    logic instr_gnt;
    logic data_gnt;

    assign full       = (count_q == MAX_CNT);
    assign fifo_empty = (count_q == 4'd0);

    // Pick the requester: a locked selection is kept, otherwise data wins unless the fetch is starving.
    always_comb begin
        sel = SEL_INSTR;
        if (lock_q) begin
            sel = sel_q;
        end else if (bus.data_req_i &&
                     !(bus.instr_req_i && (starve_cnt_q == STV_MAX))) begin
            sel = SEL_DATA;
        end
    end

    // Issue a memory request only when there is room for another outstanding transaction.
    // The outputs are held quiet while reset is asserted.
    assign mem_req   = !rst && !full && (lock_q || bus.instr_req_i || bus.data_req_i);
    assign push      = mem_req && bus.mem_gnt_i;
    assign instr_gnt = push && (sel == SEL_INSTR);
    assign data_gnt  = push && (sel == SEL_DATA);

    assign pop          = !rst && bus.mem_rvalid_i && !fifo_empty;
    assign head_is_data = id_fifo_q[rd_ptr_q];

    assign bus.mem_req_o      = mem_req;
    assign bus.instr_gnt_o    = instr_gnt;
    assign bus.data_gnt_o     = data_gnt;
    assign bus.instr_rvalid_o = pop && !head_is_data;
    assign bus.data_rvalid_o  = pop && head_is_data;
    assign bus.instr_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o   = bus.mem_rdata_i;
    assign bus.outstanding_o  = count_q;

    // Drive the memory port from the selected requester. A fetch is always a full-word read.
    always_comb begin
        bus.mem_addr_o  = bus.instr_addr_i;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'hF;
        bus.mem_wdata_o = 32'h0;
        if (sel == SEL_DATA) begin
            bus.mem_addr_o  = bus.data_addr_i;
            bus.mem_we_o    = bus.data_we_i;
            bus.mem_be_o    = bus.data_be_i;
            bus.mem_wdata_o = bus.data_wdata_i;
        end
    end

    // The ID FIFO records the owner of each granted transaction, and pops one entry per response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_fifo_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            if (push) begin
                id_fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    // The outstanding count follows push and pop. A simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Hold the selection while a request is waiting for a grant, and release it once granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= 1'b0;
            sel_q  <= SEL_INSTR;
        end else if (mem_req && !bus.mem_gnt_i) begin
            lock_q <= 1'b1;
            sel_q  <= sel;
        end else if (push) begin
            lock_q <= 1'b0;
        end
    end

    // Count consecutive data grants that overtake a waiting fetch, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else if (instr_gnt || !bus.instr_req_i) begin
            starve_cnt_q <= '0;
        end else if (data_gnt && (starve_cnt_q != STV_MAX)) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end

    // A response with nothing outstanding means the memory and the arbiter have lost track of each other.
    assert property (@(posedge clk) disable iff (rst) !(bus.mem_rvalid_i && fifo_empty));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The bench itself plays the memory.
// - Each granted transaction pushes its expected owner and read data into a queue.
// - A negedge monitor pops that queue whenever the arbiter raises a response valid.
// - Grant, address and count checks are done inline, at the negedge of each cycle.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } resp_t;

    resp_t exp_q[$];
    int    err_count   = 0;
    int    check_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic checkGrants(input string name, input logic mreq,
                               input logic igrant, input logic dgrant);
        checkOutput({name, "_grants"},
                    {29'd0, bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o},
                    {29'd0, mreq, igrant, dgrant});
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic [31:0] daddr,
                                 input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] dwdata,
                                 input logic mgnt, input logic mrvalid,
                                 input logic [31:0] mrdata);
        bus.instr_req_i  = ireq;
        bus.instr_addr_i = iaddr;
        bus.data_req_i   = dreq;
        bus.data_addr_i  = daddr;
        bus.data_we_i    = dwe;
        bus.data_be_i    = dbe;
        bus.data_wdata_i = dwdata;
        bus.mem_gnt_i    = mgnt;
        bus.mem_rvalid_i = mrvalid;
        bus.mem_rdata_i  = mrdata;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic expectResp(input logic is_data, input logic [31:0] rdata);
        resp_t r;
        r.is_data = is_data;
        r.rdata   = rdata;
        exp_q.push_back(r);
    endtask

    // Response monitor: every response valid must match the oldest expected response.
    always @(negedge clk) begin
        resp_t e;
        if (rst === 1'b0 && (bus.instr_rvalid_o === 1'b1 || bus.data_rvalid_o === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check_count++;
                err_count++;
                $display("[TB] FAIL unexpected_rvalid: got instr=%0b data=%0b, expected none at %0t",
                         bus.instr_rvalid_o, bus.data_rvalid_o, $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rvalid_route", {30'd0, bus.data_rvalid_o, bus.instr_rvalid_o},
                            e.is_data ? 32'd2 : 32'd1);
                checkOutput("rdata", e.is_data ? bus.data_rdata_o : bus.instr_rdata_o, e.rdata);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset: while reset is asserted, no request, grant or response may escape.
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'hDEAD);
        @(negedge clk);
        checkGrants("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset_rvalid", {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'd0);
        checkOutput("reset_outstanding", {28'd0, bus.outstanding_o}, 32'd0);
        advance();
        rst = 1'b0;
        idle();
        advance();

        // Lone fetch: granted in the same cycle, and answered one cycle later.
        $display("[TB] test 1: single fetch");
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        expectResp(1'b0, 32'hAAAA0001);
        @(negedge clk);
        checkGrants("t1_grant", 1'b1, 1'b1, 1'b0);
        checkOutput("t1_addr", bus.mem_addr_o, 32'h100);
        checkOutput("t1_we_be_wdata", {27'd0, bus.mem_we_o, bus.mem_be_o}, 32'h0000000F);
        checkOutput("t1_wdata", bus.mem_wdata_o, 32'h0);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA0001);
        @(negedge clk);
        checkOutput("t1_outstanding", {28'd0, bus.outstanding_o}, 32'd1);
        checkOutput("t1_data_rdata_shared", bus.data_rdata_o, 32'hAAAA0001);
        advance();
        idle();
        @(negedge clk);
        checkOutput("t1_drained", {28'd0, bus.outstanding_o}, 32'd0);
        advance();

        // Both request: data is granted first, then the fetch. Responses return in order D, I.
        $display("[TB] test 2: simultaneous requests");
        applyStimulus(1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 4'h3, 32'h55, 1'b1, 1'b0, 32'h0);
        expectResp(1'b1, 32'h000000D0);
        @(negedge clk);
        checkGrants("t2_first", 1'b1, 1'b0, 1'b1);
        checkOutput("t2_addr_d", bus.mem_addr_o, 32'h300);
        checkOutput("t2_we_be", {27'd0, bus.mem_we_o, bus.mem_be_o}, 32'h00000013);
        checkOutput("t2_wdata", bus.mem_wdata_o, 32'h55);
        advance();
        applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h000000D0);
        expectResp(1'b0, 32'h00000011);
        @(negedge clk);
        checkGrants("t2_second", 1'b1, 1'b1, 1'b0);
        checkOutput("t2_addr_i", bus.mem_addr_o, 32'h200);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h00000011);
        @(negedge clk);
        checkOutput("t2_push_pop_count", {28'd0, bus.outstanding_o}, 32'd1);
        advance();
        idle();
        @(negedge clk);
        checkOutput("t2_drained", {28'd0, bus.outstanding_o}, 32'd0);
        advance();

        // A fetch stalled by the memory stays locked even after data starts requesting.
        $display("[TB] test 3: lock while stalled");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 32'h400, (c == 3), 32'h500, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            checkGrants("t3_stall", 1'b1, 1'b0, 1'b0);
            checkOutput("t3_addr_locked", bus.mem_addr_o, 32'h400);
            advance();
        end
        applyStimulus(1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
        expectResp(1'b0, 32'h00000044);
        @(negedge clk);
        checkGrants("t3_locked_grant", 1'b1, 1'b1, 1'b0);
        checkOutput("t3_addr_grant", bus.mem_addr_o, 32'h400);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'h00000044);
        expectResp(1'b1, 32'h00005555);
        @(negedge clk);
        checkGrants("t3_data_after", 1'b1, 1'b0, 1'b1);
        checkOutput("t3_addr_d", bus.mem_addr_o, 32'h500);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h00005555);
        advance();
        idle();
        @(negedge clk);
        checkOutput("t3_drained", {28'd0, bus.outstanding_o}, 32'd0);
        advance();

        // Starvation: four data grants, then the waiting fetch, then data again.
        $display("[TB] test 4: starvation limit");
        for (int k = 1; k <= 6; k++) begin
            applyStimulus((k <= 5), 32'h600, 1'b1, 32'h700, 1'b0, 4'hF, 32'h0,
                          1'b1, (k > 1), 32'h4000 + 32'(k - 1));
            expectResp((k != 5), 32'h4000 + 32'(k));
            @(negedge clk);
            checkGrants($sformatf("t4_cycle%0d", k), 1'b1, (k == 5), (k != 5));
            advance();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h4006);
        advance();
        idle();
        @(negedge clk);
        checkOutput("t4_drained", {28'd0, bus.outstanding_o}, 32'd0);
        advance();

        // Outstanding limit: two grants fill the FIFO.
        // A pop in the full cycle does not grant; the next cycle does.
        $display("[TB] test 5: outstanding limit");
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0,
                          1'b1, (c == 6), 32'h5001);
            if (c == 1 || c == 2 || c == 7) begin
                expectResp(1'b0, (c == 7) ? 32'h5003 : 32'h5000 + 32'(c));
            end
            @(negedge clk);
            checkGrants($sformatf("t5_cycle%0d", c), (c <= 2 || c == 7), (c <= 2 || c == 7), 1'b0);
            checkOutput($sformatf("t5_count%0d", c), {28'd0, bus.outstanding_o},
                        (c == 1) ? 32'd0 : (c == 2 || c == 7) ? 32'd1 : 32'd2);
            advance();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h5002);
        @(negedge clk);
        checkOutput("t5_refull", {28'd0, bus.outstanding_o}, 32'd2);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h5003);
        advance();
        idle();
        @(negedge clk);
        checkOutput("t5_drained", {28'd0, bus.outstanding_o}, 32'd0);
        advance();

        // Reset with two outstanding transactions flushes everything. Afterwards the arbiter works normally.
        $display("[TB] test 6: reset mid-transaction");
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            advance();
        end
        idle();
        @(negedge clk);
        checkOutput("t6_before_reset", {28'd0, bus.outstanding_o}, 32'd2);
        advance();
        rst = 1'b1;
        #1;
        checkOutput("t6_async_clear", {28'd0, bus.outstanding_o}, 32'd0);
        checkGrants("t6_in_reset", 1'b0, 1'b0, 1'b0);
        advance();
        rst = 1'b0;
        advance();
        @(negedge clk);
        checkOutput("t6_no_rvalid", {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'd0);
        advance();
        applyStimulus(1'b1, 32'hA00, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        expectResp(1'b0, 32'h7001);
        @(negedge clk);
        checkGrants("t6_new_grant", 1'b1, 1'b1, 1'b0);
        checkOutput("t6_addr", bus.mem_addr_o, 32'hA00);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h7001);
        advance();
        idle();
        @(negedge clk);
        checkOutput("t6_drained", {28'd0, bus.outstanding_o}, 32'd0);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        advance();

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
